// File: rtl/tw_rom1_h_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tw_rom1_h_loader                                                           |
// | Buffers four packed twiddle words and replays them as HI then LO bursts.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tw_rom1_h_loader #(
  parameter int P_WIDTH         = 128,
  parameter int horizontal_DW   = 64,
  parameter int init_store_data = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     s_valid,
  input  logic [P_WIDTH-1:0]       s_data,
  output logic                     s_ready,
  output logic [horizontal_DW-1:0] horizontal_data_out,
  output logic [1:0]               ROM1_w,
  output logic                     rom_busy,
  output logic                     load_done,
  output logic [2:0]               words_cnt
);

  localparam int              c_BW        = (init_store_data > 1) ? $clog2(init_store_data) : 1;
  localparam logic [2:0]      c_LAST_WORD = 3'(init_store_data - 1);
  localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(init_store_data - 1);
  localparam logic [c_BW-1:0] c_BEAT_ONE  = c_BW'(1);
  localparam logic [2:0]      c_LAST_GAP  = 3'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WR_HI = 3'd2,
    S_GAP   = 3'd3,
    S_WR_LO = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                   r_state;
  logic [P_WIDTH-1:0]       r_buf [init_store_data];
  logic [c_BW-1:0]          r_beat;
  logic [2:0]               r_gap;
  logic                     r_s_ready;
  logic [1:0]               r_rom1_w;
  logic [horizontal_DW-1:0] r_data;
  logic                     r_busy;
  logic                     r_done;
  logic [2:0]               r_words_cnt;

  // Outputs are registered one cycle behind the state, so each WR_* state
  // cycle produces the beat that appears on the bus in the following cycle.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_gap       <= '0;
      r_s_ready   <= 1'b0;
      r_rom1_w    <= 2'd0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_words_cnt <= 3'd0;
      for (int i = 0; i < init_store_data; i++) r_buf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // r_done marks the visible DONE cycle, where a new start is refused
          if (load_start && !r_done) begin
            r_state     <= S_FILL;
            r_s_ready   <= 1'b1;
            r_busy      <= 1'b1;
            r_words_cnt <= 3'd0;
          end
        end
        S_FILL: begin
          if (s_valid && r_s_ready) begin
            r_buf[r_words_cnt[c_BW-1:0]] <= s_data;
            r_words_cnt                  <= r_words_cnt + 3'd1;
            if (r_words_cnt == c_LAST_WORD) begin
              r_s_ready <= 1'b0;
              r_beat    <= '0;
              r_state   <= S_WR_HI;
            end
          end
        end
        S_WR_HI: begin
          r_rom1_w <= 2'd1;
          r_data   <= r_buf[r_beat][P_WIDTH-1 -: horizontal_DW];
          r_beat   <= r_beat + c_BEAT_ONE;
          if (r_beat == c_LAST_BEAT) begin
            r_beat  <= '0;
            r_gap   <= 3'd0;
            r_state <= (GAP_CYCLES == 0) ? S_WR_LO : S_GAP;
          end
        end
        S_GAP: begin
          r_rom1_w <= 2'd0;
          r_data   <= '0;
          r_gap    <= r_gap + 3'd1;
          if (r_gap == c_LAST_GAP) r_state <= S_WR_LO;
        end
        S_WR_LO: begin
          r_rom1_w <= 2'd2;
          r_data   <= r_buf[r_beat][horizontal_DW-1:0];
          r_beat   <= r_beat + c_BEAT_ONE;
          if (r_beat == c_LAST_BEAT) begin
            r_beat  <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_rom1_w <= 2'd0;
          r_data   <= '0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready             = r_s_ready;
  assign horizontal_data_out = r_data;
  assign ROM1_w              = r_rom1_w;
  assign rom_busy            = r_busy;
  assign load_done           = r_done;
  assign words_cnt           = r_words_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tw_rom1_h_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tw_rom1_h_loader                                                        |
// | Per-cycle timeline model of tw_rom1_h_loader, GAP_CYCLES=1 and 0 builds.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tw_rom1_h_loader;

  localparam int MAXT = 64;

  logic         CLK = 1'b0;
  logic         rst = 1'b0;
  logic         load_start = 1'b0;
  logic         s_valid = 1'b0;
  logic [127:0] s_data = '0;

  logic        rdy1, rdy0, busy1, busy0, done1, done0;
  logic [63:0] hd1, hd0;
  logic [1:0]  w1, w0;
  logic [2:0]  cnt1, cnt0;

  tw_rom1_h_loader #(.GAP_CYCLES(1)) dut (
    .CLK(CLK), .rst(rst), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy1), .horizontal_data_out(hd1), .ROM1_w(w1), .rom_busy(busy1),
    .load_done(done1), .words_cnt(cnt1)
  );

  tw_rom1_h_loader #(.GAP_CYCLES(0)) dut_g0 (
    .CLK(CLK), .rst(rst), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy0), .horizontal_data_out(hd0), .ROM1_w(w0), .rom_busy(busy0),
    .load_done(done0), .words_cnt(cnt0)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus per cycle t (t=0 is the cycle in which load_start is asserted)
  logic         vld [MAXT];
  logic [127:0] din [MAXT];
  logic         ls  [MAXT];
  // Trace word: {s_ready, ROM1_w[1:0], data[63:0], rom_busy, load_done, words_cnt[2:0]}
  logic [71:0]  obs   [MAXT];
  logic [71:0]  exp_t [MAXT];
  int           last_t;
  int           last_n;
  int           model_cnt = 0;

  logic [127:0] fixed_w [4] = '{
    128'h0000000000000001_0000000000000001,
    128'hfffdffff00000003_5b11501d07d1bfa5,
    128'hfff7ffff00000001_ffeffffefffffff1,
    128'hffeffffefffffff1_52ca810d84ba33e7
  };

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [71:0] sample(input int g);
    if (g != 0) return {rdy1, w1, hd1, busy1, done1, cnt1};
    return {rdy0, w0, hd0, busy0, done0, cnt0};
  endfunction

  // mode 0: valid every cycle, 1: valid toggles 1,0,1,0, 2: random valid
  task automatic prepare(input int mode);
    int k;
    k = 0;
    for (int t = 0; t < MAXT; t++) begin
      ls[t]  = 1'b0;
      din[t] = rnd128();
      case (mode)
        0:       vld[t] = (t >= 1);
        1:       vld[t] = (t % 2 == 1);
        default: vld[t] = (t >= 1) && (($urandom_range(0, 2) != 0) || t > 16);
      endcase
      if (vld[t] && k < 4 && mode != 2) begin
        din[t] = fixed_w[k];
        k++;
      end
    end
  endtask

  // Expected timeline: 4th handshake in cycle n, HI beats n+2..n+5, GAP cycles,
  // LO beats, load_done one cycle after the last LO beat.
  task automatic build_model(input int gap, input bit abort_lo2);
    int n, k, lst, abort_t, c;
    logic [127:0] wds [4];
    logic r, b, dn;
    logic [1:0] w;
    logic [63:0] d;
    k = 0;
    n = 0;
    for (int t = 1; t < MAXT && k < 4; t++) begin
      if (vld[t]) begin
        wds[k] = din[t];
        k++;
        n = t;
      end
    end
    lst     = n + 9 + gap;
    abort_t = abort_lo2 ? n + 7 + gap : 0;
    last_t  = abort_lo2 ? abort_t + 1 : lst + 1;
    last_n  = n;
    for (int t = 0; t <= last_t; t++) begin
      r  = (t >= 1 && t <= n);
      b  = (t >= 1 && t <= lst);
      dn = (t == lst + 1);
      w  = 2'd0;
      d  = '0;
      if (t >= n + 2 && t <= n + 5) begin
        w = 2'd1;
        d = wds[t-n-2][127:64];
      end else if (t >= n + 6 + gap && t <= lst) begin
        w = 2'd2;
        d = wds[t-n-6-gap][63:0];
      end
      if (t == 0) c = model_cnt;
      else begin
        c = 0;
        for (int j = 1; j < t; j++) if (vld[j]) c++;
        if (c > 4) c = 4;
      end
      if (abort_lo2 && t > abort_t) begin
        r = 1'b0; b = 1'b0; dn = 1'b0; w = 2'd0; d = '0; c = 0;
      end
      exp_t[t] = {r, w, d, b, dn, 3'(c)};
    end
    model_cnt = abort_lo2 ? 0 : 4;
  endtask

  // Entered just after a clock edge; leaves just after the edge ending cycle last_t.
  task automatic run_load(input int gsel, input int abort_t);
    load_start = 1'b1;
    s_valid    = 1'b0;
    s_data     = rnd128();
    @(negedge CLK);
    obs[0] = sample(gsel);
    for (int t = 1; t <= last_t; t++) begin
      @(posedge CLK);
      #1;
      load_start = ls[t];
      s_valid    = vld[t];
      s_data     = din[t];
      rst        = (abort_t != 0 && t == abort_t);
      @(negedge CLK);
      obs[t] = sample(gsel);
    end
    @(posedge CLK);
    #1;
    load_start = 1'b0;
    s_valid    = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    s_valid    = 1'b1;
    s_data     = rnd128();
    load_start = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    n_checks++;
    if ({rdy1, w1, hd1, busy1, done1, cnt1} !== 72'd0)
      $display("FAIL reset_g1: got %h want 0", {rdy1, w1, hd1, busy1, done1, cnt1});
    else n_pass++;
    n_checks++;
    if ({rdy0, w0, hd0, busy0, done0, cnt0} !== 72'd0)
      $display("FAIL reset_g0: got %h want 0", {rdy0, w0, hd0, busy0, done0, cnt0});
    else n_pass++;
    @(posedge CLK);
    #1;
    rst = 1'b0;
    @(posedge CLK);
    #1;
    s_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({rdy1, w1, hd1, busy1, done1, cnt1} !== 72'd0)
      $display("FAIL reset_idle_after_release: got %h want 0", {rdy1, w1, hd1, busy1, done1, cnt1});
    else n_pass++;
    @(posedge CLK);
    #1;
    model_cnt = 0;
  endtask

  task automatic test_back_to_back();
    prepare(0);
    build_model(1, 1'b0);
    run_load(1, 0);
    for (int t = 0; t <= last_t; t++) begin
      n_checks++;
      if (obs[t] !== exp_t[t]) $display("FAIL b2b_trace cycle %0d: got %h want %h", t, obs[t], exp_t[t]);
      else n_pass++;
    end
    n_checks++;
    if (obs[6][70:5] !== {2'd1, 64'h0000000000000001})
      $display("FAIL b2b_first_hi: got %h want 1_0000000000000001", obs[6][70:5]);
    else n_pass++;
    n_checks++;
    if (obs[10][70:69] !== 2'd0) $display("FAIL b2b_gap: got %0d want 0", obs[10][70:69]);
    else n_pass++;
    n_checks++;
    if (obs[14][70:3] !== {2'd2, 64'h52ca810d84ba33e7, 1'b1, 1'b0})
      $display("FAIL b2b_last_lo: got %h want 2_52ca810d84ba33e7_1_0", obs[14][70:3]);
    else n_pass++;
    n_checks++;
    if (obs[15][4:3] !== 2'b01) $display("FAIL b2b_done_cycle15: got busy/done=%b want 01", obs[15][4:3]);
    else n_pass++;
  endtask

  task automatic test_throttled();
    prepare(1);
    build_model(1, 1'b0);
    run_load(1, 0);
    for (int t = 0; t <= last_t; t++) begin
      n_checks++;
      if (obs[t] !== exp_t[t]) $display("FAIL throttled_trace cycle %0d: got %h want %h", t, obs[t], exp_t[t]);
      else n_pass++;
    end
    n_checks++;
    if (obs[4][2:0] !== 3'd2) $display("FAIL throttled_cnt_c4: got %0d want 2", obs[4][2:0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      prepare(2);
      build_model(1, 1'b0);
      run_load(1, 0);
      for (int t = 0; t <= last_t; t++) begin
        n_checks++;
        if (obs[t] !== exp_t[t]) $display("FAIL random%0d_trace cycle %0d: got %h want %h", i, t, obs[t], exp_t[t]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    prepare(0);
    ls[7]  = 1'b1;
    ls[15] = 1'b1;
    build_model(1, 1'b0);
    run_load(1, 0);
    dones = 0;
    for (int t = 0; t <= last_t; t++) begin
      n_checks++;
      if (obs[t] !== exp_t[t]) $display("FAIL ignored_start_trace cycle %0d: got %h want %h", t, obs[t], exp_t[t]);
      else n_pass++;
      if (obs[t][3] === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 1) $display("FAIL ignored_start_done_count: got %0d want 1", dones);
    else n_pass++;
    // Next cycle must still be idle: the DONE-cycle pulse was refused
    @(negedge CLK);
    n_checks++;
    if ({rdy1, busy1, w1} !== 4'd0) $display("FAIL ignored_start_after_done: got rdy/busy/w=%b want 0000", {rdy1, busy1, w1});
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid();
    prepare(2);
    build_model(1, 1'b1);
    run_load(1, last_n + 8);
    for (int t = 0; t <= last_t; t++) begin
      n_checks++;
      if (obs[t] !== exp_t[t]) $display("FAIL reset_mid_trace cycle %0d: got %h want %h", t, obs[t], exp_t[t]);
      else n_pass++;
    end
    prepare(0);
    build_model(1, 1'b0);
    run_load(1, 0);
    for (int t = 0; t <= last_t; t++) begin
      n_checks++;
      if (obs[t] !== exp_t[t]) $display("FAIL reset_mid_reload cycle %0d: got %h want %h", t, obs[t], exp_t[t]);
      else n_pass++;
    end
  endtask

  task automatic test_gap0();
    rst = 1'b1;
    @(posedge CLK);
    #1;
    rst       = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      prepare(i == 0 ? 0 : 2);
      build_model(0, 1'b0);
      run_load(0, 0);
      for (int t = 0; t <= last_t; t++) begin
        n_checks++;
        if (obs[t] !== exp_t[t]) $display("FAIL gap0_trace%0d cycle %0d: got %h want %h", i, t, obs[t], exp_t[t]);
        else n_pass++;
      end
      n_checks++;
      if ({obs[last_n+5][70:69], obs[last_n+6][70:69]} !== 4'b0110)
        $display("FAIL gap0_hi_to_lo: got %b want 0110", {obs[last_n+5][70:69], obs[last_n+6][70:69]});
      else n_pass++;
      n_checks++;
      if (obs[last_n+10][3] !== 1'b1) $display("FAIL gap0_done_at_hi_plus_8: got %b want 1", obs[last_n+10][3]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_throttled();
    test_ignored_start();
    test_random();
    test_reset_mid();
    test_gap0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tw_rom1_h_loader.md
Name: tw_rom1_h_loader

Overview:
- Upstream feeder for the stage-0 twiddle buffer of the 1024-point/64-bit twiddle ROM.
- Accepts four 128-bit packed twiddle words (two 64-bit Goldilocks residues each) over a valid/ready stream and buffers them locally.
- Replays them as two contiguous 4-beat 64-bit bursts on the horizontal write bus: upper halves with ROM1_w=1, then lower halves with ROM1_w=2.
- Signals the read side to hold its CEN high while the ROM contents are being rewritten.

Parameters:
- P_WIDTH, 128, packed twiddle word width.
- horizontal_DW, 64, horizontal bus width; must equal P_WIDTH/2.
- init_store_data, 4, words per load; also the burst length.
- GAP_CYCLES, 1, idle cycles (ROM1_w=0) between the HI and LO bursts; legal range 0..7.

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- load_start  input  1  one-cycle pulse that begins a load. Ignored unless the FSM is in IDLE.
- s_valid  input  1  input word valid.
- s_data  input  P_WIDTH  packed twiddle word; [127:64] is the high twiddle, [63:0] the low twiddle.
- s_ready  output  1  high only in FILL.
- horizontal_data_out  output  horizontal_DW  data to the ROM's horizontal_data_in.
- ROM1_w  output  2  write select: 0 none, 1 high half, 2 low half. The value 3 is never driven.
- rom_busy  output  1  high from leaving IDLE through the end of WR_LO; the read side forces CEN=1 while this is high.
- load_done  output  1  one-cycle pulse after the last LO beat.
- words_cnt  output  3  number of words accepted in the current load (0..4).

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high.
  - While rst=1 at a CLK edge: FSM goes to IDLE; outputs go to s_ready=0, ROM1_w=0, horizontal_data_out=0, rom_busy=0, load_done=0, words_cnt=0.
  - The internal buffer buf[0..3] is cleared to 0.
  - A reset in the middle of a burst cuts the burst short. ROM1_w drops to 0 on the next cycle, so the ROM's horizontal counter re-zeroes. No partial-load recovery; software reissues load_start.
- FSM states: IDLE, FILL, WR_HI, GAP, WR_LO, DONE.
- IDLE
  - load_start=1 moves to FILL.
  - rom_busy rises on the same edge; words_cnt is cleared to 0.
- FILL
  - s_ready=1. A handshake (s_valid&s_ready) writes buf[words_cnt] <= s_data and increments words_cnt.
  - When the 4th word is accepted (words_cnt 3->4), s_ready drops on that edge and the FSM moves to WR_HI.
  - No timeout; the block waits indefinitely for words.
- WR_HI
  - Exactly 4 consecutive cycles with beat index b=0..3.
  - Registered outputs: ROM1_w=1, horizontal_data_out=buf[b][127:64].
- GAP
  - GAP_CYCLES cycles with ROM1_w=0, data held at 0.
  - GAP_CYCLES=0 skips the state; WR_LO then directly follows the 4th HI beat.
- WR_LO
  - 4 cycles with ROM1_w=2, horizontal_data_out=buf[b][63:0], b=0..3.
- DONE
  - One cycle: load_done=1, rom_busy=0, ROM1_w=0, then back to IDLE.
- Beat contiguity
  - Beats inside a burst are never stalled. The downstream horizontal counter advances on every ROM1_w!=0 cycle and wraps at 3, so entry b receives beat b.
- Latency
  - load_start to first HI beat = 1 (FILL entry) + number of FILL cycles + 1.
  - With s_valid held at 1: first HI beat at cycle 6 after the load_start edge.
  - load_done at 4+GAP_CYCLES+4 cycles after the first HI beat.
- Simultaneous events
  - load_start during any non-IDLE state is ignored.
  - load_start in the DONE cycle is also ignored; it is accepted in IDLE one cycle later.
  - s_valid outside FILL is ignored and not consumed.
- Width rules
  - No arithmetic on data; data is a pure slice/copy.
  - words_cnt saturates at 4.

Test Plan:
- Reset sequence: rst=1 for 3 cycles, then 0 -> ROM1_w=0, s_ready=0, rom_busy=0, load_done=0, words_cnt=0; buf reads back 0.
- Back-to-back load: load_start, then s_valid=1 with words 0x0000000000000001_0000000000000001, 0xfffdffff00000003_5b11501d07d1bfa5, 0xfff7ffff00000001_ffeffffefffffff1, 0xffeffffefffffff1_52ca810d84ba33e7 ->
  - HI beats 0x0000000000000001, 0xfffdffff00000003, 0xfff7ffff00000001, 0xffeffffefffffff1 with ROM1_w=1.
  - Then 1 gap cycle with ROM1_w=0.
  - Then LO beats 0x0000000000000001, 0x5b11501d07d1bfa5, 0xffeffffefffffff1, 0x52ca810d84ba33e7 with ROM1_w=2.
  - load_done pulses at cycle 15 after load_start; rom_busy is high cycles 1..14.
- Throttled source: s_valid toggling 1,0,1,0 -> words_cnt steps 1..4 only on handshakes; beat order and values identical to the back-to-back case; bursts still contiguous.
- Ignored start: load_start pulsed during WR_HI and during DONE -> no state change; exactly one load_done for the original load.
- Reset mid-burst: rst asserted during the 2nd LO beat -> next cycle ROM1_w=0, rom_busy=0, FSM in IDLE; a following full load then completes normally.
- GAP_CYCLES=0 build: the 4th HI beat (ROM1_w=1) is immediately followed by the 1st LO beat (ROM1_w=2); load_done comes 8 cycles after the first HI beat.
